// File: rtl/mprj_io_cfg_loader_if.sv
// Configuration-store read port: the loader issues cfg_rd/cfg_addr and the
// store returns cfg_rdata one cycle later.
interface mprj_io_cfg_loader_if #(
  parameter int NUM_PADS = 27,
  parameter int CFG_BITS = 13
);
  localparam int ADDR_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  logic              cfg_rd;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_BITS-1:0] cfg_rdata;

  modport master (output cfg_rd, output cfg_addr, input cfg_rdata);
  modport slave  (input cfg_rd, input cfg_addr, output cfg_rdata);
endinterface

// File: rtl/mprj_io_cfg_loader.sv
// Reads one config word per pad (farthest pad first) and shifts it MSB-first
// into the pad chain, then pulses serial_load to transfer the whole chain.
module mprj_io_cfg_loader #(
  parameter int NUM_PADS = 27,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic start,
  input  logic abort,
  mprj_io_cfg_loader_if.master cfg,
  output logic serial_clock,
  output logic serial_data,
  output logic serial_load,
  output logic busy,
  output logic done,
  output logic aborted
);
  localparam int PAD_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
  localparam int BIT_W = $clog2(CFG_BITS + 1);
  localparam int DIV_W = $clog2(2 * CLK_DIV);

  localparam logic [PAD_W-1:0] PAD_LAST  = PAD_W'(NUM_PADS - 1);
  localparam logic [BIT_W-1:0] BITS_INIT = BIT_W'(CFG_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_LOAD    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [PAD_W-1:0]    pad_q, pad_d;
  logic [BIT_W-1:0]    bits_q, bits_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CFG_BITS-1:0] sreg_q, sreg_d;

  logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
  logic             cfg_rd_q, cfg_rd_d;
  logic [PAD_W-1:0] cfg_addr_q, cfg_addr_d;
  logic             sclk_q, sclk_d, sdata_q, sdata_d, sload_q, sload_d;

  always_comb begin
    state_d   = state_q;
    pad_d     = pad_q;
    bits_d    = bits_q;
    div_d     = div_q;
    sreg_d    = sreg_q;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        pad_d   = PAD_LAST;
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        sreg_d  = cfg.cfg_rdata;
        bits_d  = BITS_INIT;
        div_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sreg_d = sreg_q << 1;
          bits_d = bits_q - BIT_W'(1);
          if (bits_q == BIT_W'(1)) begin
            if (pad_q != '0) begin
              pad_d   = pad_q - PAD_W'(1);
              state_d = S_FETCH;
            end else begin
              state_d = S_LOAD;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LOAD: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_FINISH;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      pad_d     = '0;
      bits_d    = '0;
      div_d     = '0;
      sreg_d    = '0;
      aborted_d = 1'b1;
    end

    // Outputs are decoded from next-state values so each flop lines up with its state.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    cfg_rd_d   = (state_d == S_FETCH);
    cfg_addr_d = pad_d;
    sclk_d     = (state_d == S_SHIFT) && (div_d >= DIV_HALF);
    sdata_d    = (state_d == S_SHIFT) && sreg_d[CFG_BITS-1];
    sload_d    = (state_d == S_LOAD);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      pad_q      <= '0;
      bits_q     <= '0;
      div_q      <= '0;
      sreg_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      cfg_rd_q   <= 1'b0;
      cfg_addr_q <= '0;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sload_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pad_q      <= pad_d;
      bits_q     <= bits_d;
      div_q      <= div_d;
      sreg_q     <= sreg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      cfg_rd_q   <= cfg_rd_d;
      cfg_addr_q <= cfg_addr_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      sload_q    <= sload_d;
    end
  end

  assign cfg.cfg_rd   = cfg_rd_q;
  assign cfg.cfg_addr = cfg_addr_q;
  assign serial_clock = sclk_q;
  assign serial_data  = sdata_q;
  assign serial_load  = sload_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
endmodule
